// File: rtl/bru_predictor_if.sv
// Fetch-lookup / execute-resolve bundle between the core pipeline and the branch predictor.
// master = pipeline side, slave = predictor.
interface bru_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic [XLEN-1:0] f_pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [1:0]      ex_is_control;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [15:0]     mispredict_cnt;

  modport master (
    output f_pc, ex_valid, ex_pc, ex_is_control, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  f_pred_taken, f_pred_target, redirect_valid, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  f_pc, ex_valid, ex_pc, ex_is_control, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output f_pred_taken, f_pred_target, redirect_valid, redirect_pc, mispredict_cnt
  );
endinterface

// File: rtl/bru_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; resolves mispredicts at execute
// and issues a registered one-cycle redirect plus a saturating mispredict count.
module bru_predictor #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic clk,
  input  logic rst,
  bru_predictor_if.slave bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [ENTRIES-1:0]           valid_q, valid_d;
  logic [ENTRIES-1:0][TAGW-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0]      ctr_q, ctr_d;
  logic                         redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]              redirect_pc_q, redirect_pc_d;
  logic [15:0]                  cnt_q, cnt_d;

  logic [IDXW-1:0] f_idx, ex_idx;
  logic [TAGW-1:0] f_tag, ex_tag;
  logic            f_hit, ex_hit, ex_ctl, mispredict;
  logic [XLEN-1:0] f_pc_inc, ex_pc_inc;

  // Lookup reads only registered state, so a same-cycle update is not visible here.
  assign f_idx    = bus.f_pc[IDXW+1:2];
  assign f_tag    = bus.f_pc[XLEN-1:IDXW+2];
  assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pc_inc = bus.f_pc + PC_INC;

  assign bus.f_pred_taken  = f_hit && ctr_q[f_idx][1];
  assign bus.f_pred_target = (f_hit && ctr_q[f_idx][1]) ? tgt_q[f_idx] : f_pc_inc;

  assign ex_idx    = bus.ex_pc[IDXW+1:2];
  assign ex_tag    = bus.ex_pc[XLEN-1:IDXW+2];
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_pc_inc = bus.ex_pc + PC_INC;
  assign ex_ctl    = (bus.ex_is_control != 2'b00);

  // Non-control instructions that were predicted taken are aliases of some branch entry.
  assign mispredict = bus.ex_valid &&
                      (ex_ctl ? ((bus.ex_pred_taken != bus.ex_taken) ||
                                 (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)))
                              : bus.ex_pred_taken);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (bus.ex_valid) begin
      if (ex_ctl) begin
        if (ex_hit) begin
          if (bus.ex_taken) begin
            ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
            tgt_d[ex_idx] = bus.ex_target;
          end else begin
            ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
          end
        end else if (bus.ex_taken) begin
          valid_d[ex_idx] = 1'b1;
          tag_d[ex_idx]   = ex_tag;
          tgt_d[ex_idx]   = bus.ex_target;
          ctr_d[ex_idx]   = 2'b10;
        end
      end else if (bus.ex_pred_taken && ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    cnt_d            = cnt_q;
    if (mispredict) begin
      redirect_pc_d = (ex_ctl && bus.ex_taken) ? bus.ex_target : ex_pc_inc;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      tag_q            <= '0;
      tgt_q            <= '0;
      ctr_q            <= {ENTRIES{CTR_INIT}};
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      tgt_q            <= tgt_d;
      ctr_q            <= ctr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_q            <= cnt_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_bru_predictor.sv
// Directed bench for bru_predictor (XLEN=32, ENTRIES=16, CTR_INIT=01).
module tb_bru_predictor;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bru_predictor_if #(.XLEN(32)) bus ();

  bru_predictor #(.XLEN(32), .ENTRIES(16), .CTR_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [1:0] ctl, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_is_control  = ctl;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt);
    bus.f_pc = pc;
    #1;
    chk({tag, "_taken"}, 32'(bus.f_pred_taken), 32'(tk));
    chk({tag, "_target"}, bus.f_pred_target, tgt);
  endtask

  task automatic chk_redir(input string tag, input logic v, input logic [31:0] pc,
                           input logic [15:0] cnt);
    chk({tag, "_rv"}, 32'(bus.redirect_valid), 32'(v));
    chk({tag, "_rpc"}, bus.redirect_pc, pc);
    chk({tag, "_cnt"}, 32'(bus.mispredict_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    bus.f_pc = 32'h8;
    ex(2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    step();
    chk_pred("in_reset", 32'h8, 1'b0, 32'hC);
    chk_redir("in_reset", 1'b0, 32'h0, 16'd0);
    step();
    rst = 1'b0;
    step();
    chk_pred("post_reset", 32'h8, 1'b0, 32'hC);
    chk_redir("post_reset", 1'b0, 32'h0, 16'd0);

    // Taken miss allocates at counter 10 and redirects.
    ex(2'b01, 32'h8, 1'b1, 32'h12345678, 1'b0, 32'h0);
    step();
    chk_redir("beq_alloc", 1'b1, 32'h12345678, 16'd1);
    chk_pred("beq_alloc", 32'h8, 1'b1, 32'h12345678);
    idle();
    step();
    chk_redir("one_shot", 1'b0, 32'h12345678, 16'd1);

    // Not taken twice: 10 -> 01 (mispredict), 01 -> 00 (correct).
    ex(2'b01, 32'h8, 1'b0, 32'h0, 1'b1, 32'h12345678);
    step();
    chk_redir("nt1", 1'b1, 32'hC, 16'd2);
    chk_pred("nt1", 32'h8, 1'b0, 32'hC);
    ex(2'b01, 32'h8, 1'b0, 32'h0, 1'b0, 32'hC);
    step();
    chk_redir("nt2", 1'b0, 32'hC, 16'd2);
    chk_pred("nt2", 32'h8, 1'b0, 32'hC);

    // Retrain 00 -> 01 -> 10.
    ex(2'b01, 32'h8, 1'b1, 32'h12345678, 1'b0, 32'hC);
    step();
    chk_redir("retrain1", 1'b1, 32'h12345678, 16'd3);
    chk_pred("retrain1", 32'h8, 1'b0, 32'hC);
    step();
    chk_redir("retrain2", 1'b1, 32'h12345678, 16'd4);
    chk_pred("retrain2", 32'h8, 1'b1, 32'h12345678);

    // JALR with wrong predicted target.
    ex(2'b11, 32'h8, 1'b1, 32'h12348AC6, 1'b1, 32'h12345678);
    step();
    chk_redir("jalr", 1'b1, 32'h12348AC6, 16'd5);
    chk_pred("jalr", 32'h8, 1'b1, 32'h12348AC6);
    ex(2'b11, 32'h8, 1'b1, 32'h12348AC6, 1'b1, 32'h12348AC6);
    step();
    chk_redir("jalr_ok", 1'b0, 32'h12348AC6, 16'd5);

    // Alias at index 2 with tag mismatch: entry for 0x8 survives.
    ex(2'b00, 32'h48, 1'b0, 32'h0, 1'b1, 32'h12348AC6);
    step();
    chk_redir("alias", 1'b1, 32'h4C, 16'd6);
    chk_pred("alias_keep", 32'h8, 1'b1, 32'h12348AC6);
    chk_pred("alias_miss", 32'h48, 1'b0, 32'h4C);

    // Non-control predicted taken with matching tag invalidates the entry.
    ex(2'b00, 32'h8, 1'b0, 32'h0, 1'b1, 32'h12348AC6);
    step();
    chk_redir("inval", 1'b1, 32'hC, 16'd7);
    chk_pred("inval", 32'h8, 1'b0, 32'hC);

    // Same-cycle lookup sees pre-update contents.
    ex(2'b10, 32'h10, 1'b1, 32'h100, 1'b0, 32'h14);
    chk_pred("nobypass_pre", 32'h10, 1'b0, 32'h14);
    step();
    chk_pred("nobypass_post", 32'h10, 1'b1, 32'h100);
    chk_redir("jal", 1'b1, 32'h100, 16'd8);

    // PC+4 wrap on both lookup and redirect.
    chk_pred("wrap_f", 32'hFFFFFFFC, 1'b0, 32'h0);
    ex(2'b00, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    chk_redir("wrap_ex", 1'b1, 32'h0, 16'd9);

    // ex_valid low: other fields ignored.
    ex(2'b01, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0);
    idle();
    step();
    chk_redir("idle", 1'b0, 32'h0, 16'd9);
    chk_pred("idle", 32'h10, 1'b1, 32'h100);

    // Counter saturation.
    ex(2'b00, 32'h200, 1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 65520; i++) @(posedge clk);
    #1;
    chk("cnt_near", 32'(bus.mispredict_cnt), 32'h0000FFF9);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(bus.mispredict_cnt), 32'h0000FFFF);
    step();
    chk("cnt_hold", 32'(bus.mispredict_cnt), 32'h0000FFFF);

    // Reset mid-stream discards the coincident mispredict.
    rst = 1'b1;
    step();
    chk_redir("mid_reset", 1'b0, 32'h0, 16'd0);
    chk_pred("mid_reset", 32'h10, 1'b0, 32'h14);
    rst = 1'b0;
    ex(2'b01, 32'h10, 1'b1, 32'h200, 1'b0, 32'h14);
    step();
    chk_redir("first_upd", 1'b1, 32'h200, 16'd1);
    chk_pred("first_upd", 32'h10, 1'b1, 32'h200);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bru_predictor.md
BRU_PREDICTOR -- requirements
Module: bru_predictor

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, >= 2; IDXW = log2(ENTRIES).
REQ-003 Parameter CTR_INIT, default 2'b01, counter reset value (weakly not-taken).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 f_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 f_pred_taken  output  1  predicted taken for f_pc.
REQ-008 f_pred_target  output  XLEN  predicted next PC for f_pc.
REQ-009 ex_valid  input  1  execute-stage resolution valid this cycle.
REQ-010 ex_pc  input  XLEN  PC of resolving instruction.
REQ-011 ex_is_control  input  2  00 none, 01 conditional branch, 10 JAL, 11 JALR.
REQ-012 ex_taken  input  1  actual outcome (BRU is_taken).
REQ-013 ex_target  input  XLEN  actual target (BRU pc_bru).
REQ-014 ex_pred_taken  input  1  prediction made at fetch for ex_pc.
REQ-015 ex_pred_target  input  XLEN  predicted target made at fetch for ex_pc.
REQ-016 redirect_valid  output  1  registered pipeline flush/redirect request.
REQ-017 redirect_pc  output  XLEN  registered correct next PC.
REQ-018 mispredict_cnt  output  16  saturating mispredict counter.

Function
REQ-019 Each entry holds valid, tag = pc[XLEN-1:IDXW+2], target[XLEN-1:0], 2-bit saturating counter; index = pc[IDXW+1:2]; pc[1:0] ignored.
REQ-020 Lookup combinational: hit = valid && tag match at index(f_pc).
REQ-021 f_pred_taken = hit && counter[1]; f_pred_target = stored target if f_pred_taken, else f_pc+4 (mod 2^XLEN).
REQ-022 Update when ex_valid && ex_is_control != 00, at the rising edge of the same cycle.
REQ-023 Hit update: taken -> counter+1 saturating at 3, target <= ex_target; not taken -> counter-1 saturating at 0, target unchanged.
REQ-024 Miss update: taken -> allocate (overwrite) with valid=1, new tag, target=ex_target, counter=2'b10; not taken -> no write.
REQ-025 Mispredict when ex_valid and either: ex_is_control != 00 and (ex_pred_taken != ex_taken, or ex_taken && ex_pred_target != ex_target); or ex_is_control == 00 and ex_pred_taken == 1.
REQ-026 Aliased non-control hit (ex_is_control == 00, ex_pred_taken == 1): entry at index(ex_pc) invalidated if tag matches; redirect to ex_pc+4.
REQ-027 Mispredict in cycle N -> redirect_valid = 1 in cycle N+1 for exactly one cycle; redirect_pc = ex_taken ? ex_target : ex_pc+4 (ex_pc+4 for aliased case).
REQ-028 No mispredict -> redirect_valid = 0 next cycle; redirect_pc holds last value.
REQ-029 mispredict_cnt increments by 1 per mispredict; holds at 16'hFFFF.
REQ-030 Same-cycle lookup and update of one index: lookup returns pre-update contents (no bypass).
REQ-031 ex_valid = 0: no table, counter or redirect change except redirect_valid <= 0.
REQ-032 PC+4 at 32'hFFFFFFFC wraps to 0.

Reset
REQ-033 rst high at edge: all valid bits 0, all counters CTR_INIT, redirect_valid 0, redirect_pc 0, mispredict_cnt 0; a coincident update is discarded.
REQ-034 During reset, f_pred_taken = 0 and f_pred_target = f_pc+4 from the first post-reset edge.
REQ-035 Update accepted on the first edge after rst falls.

Verification
REQ-036 After reset, f_pc=0x8 -> f_pred_taken=0, f_pred_target=0xC; mispredict_cnt=0.
REQ-037 BEQ ex_pc=0x8, taken, ex_target=0x12345678, ex_pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x12345678, cnt=1; then f_pc=0x8 -> taken, target 0x12345678.
REQ-038 Same branch not taken twice (pred_taken=1 then 0) -> first: redirect 0xC, counter 10->01; second: no redirect; f_pc=0x8 predicts not-taken.
REQ-039 JALR ex_pc=0x8, taken, ex_target=0x12348AC6, ex_pred_target=0x12345678, pred_taken=1 -> redirect_pc=0x12348AC6; stored target updated.
REQ-040 ENTRIES=16: ex_pc=0x48 aliases 0x8 (index 2), ex_is_control=00, ex_pred_taken=1 -> redirect_pc=0x4C; entry for 0x8 untouched (tag mismatch).
REQ-041 Force 65536 mispredicts -> mispredict_cnt stays 16'hFFFF; assert rst mid-sequence -> all outputs return to reset values next edge.
